// File: rtl/swerv_types.sv
// -----------------------------------------------------------------------------
// swerv_types
// Shared types and constants for the LSU bus clock-enable generator.
//   BUSCLK_RATIO_W : default width of the bus clock ratio field
//   busclk_state_t : ratio-change sequencer states (RUN / DRAIN / ACK)
// -----------------------------------------------------------------------------
package swerv_types;

  localparam int BUSCLK_RATIO_W = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } busclk_state_t;

endpackage

// File: rtl/lsu_busclk_cnt.sv
// -----------------------------------------------------------------------------
// lsu_busclk_cnt
// Bus-period counter. It counts 0..ratio_cur and then wraps to 0. The enable
// is decoded in the last core cycle of each bus period.
// Optional feature macro: RV_BUSCLK_PRE_EN adds clk_en_pre, which is high
// in the cycle before each clk_en.
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   ratio_cur     ratio currently in effect (divide = ratio_cur+1)
//   load_zero     synchronous restart of the count at 0
//   at_boundary   raw cnt==ratio_cur (not gated by reset)
//   clk_en        bus clock enable, forced low during reset
//   clk_en_pre    (RV_BUSCLK_PRE_EN only) pre-enable, forced low during reset
// -----------------------------------------------------------------------------
module lsu_busclk_cnt #(
  parameter int RATIO_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RATIO_W-1:0] ratio_cur,
  input  logic               load_zero,
  output logic               at_boundary,
  output logic               clk_en
`ifdef RV_BUSCLK_PRE_EN
  ,
  output logic               clk_en_pre
`endif
);

  localparam logic [RATIO_W-1:0] CNT_ONE = RATIO_W'(1);

  logic [RATIO_W-1:0] cnt;

  assign at_boundary = (cnt == ratio_cur);
  assign clk_en      = at_boundary & ~rst;

  // The wrap is an explicit compare. It does not depend on counter overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load_zero || at_boundary) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

`ifdef RV_BUSCLK_PRE_EN
  // At divide-by-1 every cycle precedes a pulse, so the pre-enable is held high.
  assign clk_en_pre = ~rst & ((ratio_cur == '0) | (cnt == (ratio_cur - CNT_ONE)));
`endif

endmodule

// File: rtl/lsu_bus_clken_gen.sv
// -----------------------------------------------------------------------------
// lsu_bus_clken_gen
// Generates the LSU bus clock enable by dividing the core clock by
// ratio_cur+1. Ratio changes arrive over a valid/ready handshake. A change
// takes effect only on a bus-period boundary while the bus is idle, and a
// one-cycle ack follows.
// Optional feature macro: RV_BUSCLK_PRE_EN adds the lsu_bus_clk_en_pre output.
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   ratio_req_valid     new ratio request
//   ratio_req           requested ratio
//   ratio_req_ready     request accepted when valid & ready
//   bus_idle            no in-flight bus traffic
//   lsu_bus_clk_en      high in the last core cycle of each bus period
//   ratio_cur           ratio in effect
//   ratio_chg_ack       one-cycle pulse: the pending ratio is now in effect
//   drain_active        change pending, waiting for boundary and idle
//   lsu_bus_clk_en_pre  (RV_BUSCLK_PRE_EN) high the cycle before lsu_bus_clk_en
//
// state | meaning
// RUN   | dividing at ratio_cur, accepting requests
// DRAIN | request held in ratio_pend, waiting for boundary with bus idle
// ACK   | new ratio in effect, ack pulse, first cycle of new period
// -----------------------------------------------------------------------------
module lsu_bus_clken_gen
  import swerv_types::*;
#(
  parameter int RATIO_W     = BUSCLK_RATIO_W,
  parameter int RESET_RATIO = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ratio_req_valid,
  input  logic [RATIO_W-1:0] ratio_req,
  output logic               ratio_req_ready,
  input  logic               bus_idle,
  output logic               lsu_bus_clk_en,
  output logic [RATIO_W-1:0] ratio_cur,
  output logic               ratio_chg_ack,
  output logic               drain_active
`ifdef RV_BUSCLK_PRE_EN
  ,
  output logic               lsu_bus_clk_en_pre
`endif
);

  localparam logic [RATIO_W-1:0] RESET_VAL = RATIO_W'(RESET_RATIO);

  busclk_state_t      state_q, state_d;
  logic [RATIO_W-1:0] ratio_pend;
  logic               pend_load;
  logic               cur_load;
  logic               at_boundary;

  lsu_busclk_cnt #(.RATIO_W(RATIO_W)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .ratio_cur   (ratio_cur),
    .load_zero   (cur_load),
    .at_boundary (at_boundary),
    .clk_en      (lsu_bus_clk_en)
`ifdef RV_BUSCLK_PRE_EN
    ,
    .clk_en_pre  (lsu_bus_clk_en_pre)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      ratio_cur  <= RESET_VAL;
      ratio_pend <= '0;
    end else begin
      state_q <= state_d;
      if (pend_load) ratio_pend <= ratio_req;
      if (cur_load)  ratio_cur  <= ratio_pend;
    end
  end

  // The swap happens on the boundary cycle. That cycle still emits the
  // old-ratio pulse, so no bus period is cut short or stretched.
  always_comb begin
    state_d   = state_q;
    pend_load = 1'b0;
    cur_load  = 1'b0;
    case (state_q)
      RUN: begin
        if (ratio_req_valid) begin
          pend_load = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (bus_idle && at_boundary) begin
          cur_load = 1'b1;
          state_d  = ACK;
        end
      end
      ACK:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs decode the state flop only. Reset forces them low.
  assign ratio_req_ready = (state_q == RUN)   & ~rst;
  assign drain_active    = (state_q == DRAIN) & ~rst;
  assign ratio_chg_ack   = (state_q == ACK)   & ~rst;

endmodule

// File: tb/tb_lsu_bus_clken_gen.sv
module tb_lsu_bus_clken_gen;

  localparam int RW = 3;
  localparam int RR = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [RW-1:0] req;
  logic          ready;
  logic          idle;
  logic          en;
  logic [RW-1:0] ratio_cur;
  logic          ack;
  logic          drain;
`ifdef RV_BUSCLK_PRE_EN
  logic          pre;
`endif

  always #5 clk = ~clk;

  lsu_bus_clken_gen #(.RATIO_W(RW), .RESET_RATIO(RR)) dut (
    .clk             (clk),
    .rst             (rst),
    .ratio_req_valid (valid),
    .ratio_req       (req),
    .ratio_req_ready (ready),
    .bus_idle        (idle),
    .lsu_bus_clk_en  (en),
    .ratio_cur       (ratio_cur),
    .ratio_chg_ack   (ack),
    .drain_active    (drain)
`ifdef RV_BUSCLK_PRE_EN
    ,
    .lsu_bus_clk_en_pre (pre)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Event-level reference: the model tracks the cycle number of the next
  // pulse, and the cycle of any expected ack. It does not model a counter.
  int cyc;
  int m_ratio;
  int m_next;
  int m_pend_val;
  int m_ack_cyc;
  bit m_pending;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d t=%0t", name, act, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    cyc        = 0;
    m_ratio    = RR;
    m_next     = RR;
    m_pending  = 1'b0;
    m_pend_val = 0;
    m_ack_cyc  = -1;
    exp_q.delete();
  endtask

  function automatic bit m_ready();
    return !m_pending && (cyc != m_ack_cyc);
  endfunction

  task automatic step(input bit r, input bit v, input int rq, input bit id);
    bit acc;
    rst   = r;
    valid = v;
    req   = rq[RW-1:0];
    idle  = id;
    @(negedge clk);
    if (r) begin
      check("rst_en",    int'(en),    0);
      check("rst_ready", int'(ready), 0);
      check("rst_drain", int'(drain), 0);
      check("rst_ack",   int'(ack),   0);
`ifdef RV_BUSCLK_PRE_EN
      check("rst_pre",   int'(pre),   0);
`endif
    end else begin
      check("en",        int'(en),        int'(cyc == m_next));
      check("ready",     int'(ready),     int'(m_ready()));
      check("drain",     int'(drain),     int'(m_pending));
      check("ack",       int'(ack),       int'(cyc == m_ack_cyc));
      check("ratio_cur", int'(ratio_cur), m_ratio);
`ifdef RV_BUSCLK_PRE_EN
      check("pre", int'(pre), int'((m_ratio == 0) || (cyc + 1 == m_next)));
`endif
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      acc = m_ready() && v;
      if (cyc == m_next) begin
        if (m_pending && id) begin
          m_ratio   = m_pend_val;
          m_pending = 1'b0;
          m_ack_cyc = cyc + 1;
          m_next    = cyc + 1 + m_ratio;
        end else begin
          m_next = cyc + m_ratio + 1;
        end
      end
      if (acc) begin
        m_pending  = 1'b1;
        m_pend_val = rq;
        exp_q.push_back(rq);
      end
      cyc++;
    end
    #1;
  endtask

  // Scoreboard monitor: each ack must match the oldest accepted request.
  always @(negedge clk) begin
    if (ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_ack actual=unexpected_ack required=no_ack t=%0t", $time);
      end else begin
        check("sb_ratio", int'(ratio_cur), exp_q.pop_front());
      end
    end
  end

  initial begin
    bit done;
    model_reset();
    repeat (3) step(1, 0, 0, 1);
    repeat (8) step(0, 0, 0, 1);

    // ratio 3 with the bus idle
    step(0, 1, 3, 1);
    repeat (20) step(0, 0, 0, 1);

    // ratio 1 while the bus is busy, then idle
    step(0, 1, 1, 0);
    repeat (10) step(0, 0, 0, 0);
    repeat (12) step(0, 0, 0, 1);

    // valid held during DRAIN with another value must be ignored
    step(0, 1, 5, 0);
    repeat (6) step(0, 1, 2, 0);
    repeat (16) step(0, 0, 0, 1);

    // reset on the boundary cycle that would lead to ACK
    step(0, 1, 6, 1);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_pending && cyc == m_next) begin
        step(1, 0, 0, 1);
        done = 1'b1;
      end else begin
        step(0, 0, 0, 1);
      end
    end
    check("rst_before_ack_reached", int'(done), 1);
    repeat (10) step(0, 0, 0, 1);

    // ratio 2, then back to ratio 0
    step(0, 1, 2, 1);
    repeat (15) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    repeat (6) step(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(99) == 0, $urandom_range(3) == 0,
           int'($urandom_range(7)), $urandom_range(3) != 0);
    end

    repeat (30) step(0, 0, 0, 1);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
